// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// States: IDLE serves hits and accepts requests. MISS waits for the memory
// word. DROP waits for a flushed fetch's word, which still fills the line.
// Build option: define ICACHE_EN to enable the line storage. Without it,
// every access goes to memory (pass-through) with the same timing.
module icache #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_handle,
  output logic        inst_ready,
  output logic [31:0] inst_data,
  input  logic        rob_clear,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        hit_q, hit_d;
  logic [31:0] data_q, data_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        hit_c;
  logic        fill_c;
  logic [31:0] line_data_c;
  logic        unused_c;

  // Accept only in IDLE, never in a flush cycle, never while frozen
  assign inst_handle = (state_q == S_IDLE) & inst_req & ~rob_clear & rdy_in;

  // The outstanding word returns (MISS or DROP), so the line is written
  assign fill_c = rdy_in & mem_done & ((state_q == S_MISS) | (state_q == S_DROP));

  // A flush in the response cycle of a hit cancels that response
  assign inst_ready = ready_q & ~(hit_q & rob_clear);
  assign inst_data  = data_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

`ifdef ICACHE_EN
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 30 - INDEX_BITS;

  logic [INDEX_BITS-1:0] req_idx_c, fill_idx_c;
  logic [TAG_W-1:0]      req_tag_c, fill_tag_c;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q [LINES];
  logic [31:0]           dat_q [LINES];

  assign req_idx_c   = inst_addr[INDEX_BITS+1:2];
  assign req_tag_c   = inst_addr[31:INDEX_BITS+2];
  assign fill_idx_c  = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag_c  = mem_addr_q[31:INDEX_BITS+2];
  assign hit_c       = valid_q[req_idx_c] & (tag_q[req_idx_c] == req_tag_c);
  assign line_data_c = dat_q[req_idx_c];
  assign unused_c    = ^inst_addr[1:0];

  // Valid bits: cleared by reset, set when a line is filled
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (fill_c) begin
      valid_q[fill_idx_c] <= 1'b1;
    end
  end

  // Tag and data storage; a fill overwrites whatever the line held
  always_ff @(posedge clk_in) begin
    if (fill_c) begin
      tag_q[fill_idx_c] <= fill_tag_c;
      dat_q[fill_idx_c] <= mem_rdata;
    end
  end
`else
  assign hit_c       = 1'b0;
  assign line_data_c = 32'h0;
  assign unused_c    = ^{inst_addr[1:0], 32'(INDEX_BITS), fill_c};
`endif

  // Next-state and response logic; everything holds while rdy_in is low
  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    hit_d      = 1'b0;
    data_d     = data_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (!rdy_in) begin
      ready_d = ready_q;
      hit_d   = hit_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inst_handle) begin
            if (hit_c) begin
              ready_d = 1'b1;
              hit_d   = 1'b1;
              data_d  = line_data_c;
            end else begin
              state_d    = S_MISS;
              mem_req_d  = 1'b1;
              mem_addr_d = {inst_addr[31:2], 2'b00};
            end
          end
        end
        S_MISS: begin
          if (mem_done) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            if (!rob_clear) begin
              ready_d = 1'b1;
              data_d  = mem_rdata;
            end
          end else if (rob_clear) begin
            state_d = S_DROP;
          end
        end
        S_DROP: begin
          if (mem_done) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end
        end
        default: begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      hit_q      <= 1'b0;
      data_q     <= 32'h0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      hit_q      <= hit_d;
      data_q     <= data_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_icache;

  localparam int unsigned LINES = 16;
`ifdef ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_handle;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        rob_clear = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  icache #(.INDEX_BITS(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_handle(inst_handle),
    .inst_ready(inst_ready), .inst_data(inst_data), .rob_clear(rob_clear),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done),
    .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding memory read, whether its result is
  // still wanted, a pending response, and the cache contents keyed by line.
  bit          m_busy, m_keep, m_ready, m_hit;
  logic [31:0] m_addr, m_data;
  bit          c_valid [LINES];
  logic [31:0] c_addr  [LINES];
  logic [31:0] c_data  [LINES];

  // Values sampled from the DUT in the most recent cycle
  logic        s_handle, s_ready, s_mem_req;
  logic [31:0] s_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
  endfunction

  task automatic reset_model();
    m_busy = 0; m_keep = 0; m_ready = 0; m_hit = 0;
    m_addr = 32'h0; m_data = 32'h0;
    for (int i = 0; i < LINES; i++) begin
      c_valid[i] = 0; c_addr[i] = 32'h0; c_data[i] = 32'h0;
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model
  task automatic cycle(input logic req, input logic [31:0] addr, input logic clr,
                       input logic rdy, input logic done, input logic [31:0] rdata);
    bit          e_handle, e_ready, nxt_ready, nxt_hit;
    logic [31:0] nxt_data;
    int          li;
    @(negedge clk_in);
    inst_req = req; inst_addr = addr; rob_clear = clr;
    rdy_in = rdy; mem_done = done; mem_rdata = rdata;
    #1;
    e_handle = !m_busy && req && !clr && rdy;
    e_ready  = m_ready && !(m_hit && clr);
    s_handle = inst_handle; s_ready = inst_ready; s_data = inst_data; s_mem_req = mem_req;
    check_eq("inst_handle", 32'(inst_handle), 32'(e_handle));
    check_eq("inst_ready", 32'(inst_ready), 32'(e_ready));
    check_eq("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) check_eq("mem_addr", mem_addr, m_addr);
    if (e_ready) check_eq("inst_data", inst_data, m_data);
    if (rdy) begin
      nxt_ready = 0; nxt_hit = 0; nxt_data = m_data;
      if (m_busy && done) begin
        li = line_of(m_addr);
        c_valid[li] = 1; c_addr[li] = m_addr; c_data[li] = rdata;
        if (m_keep && !clr) begin
          nxt_ready = 1; nxt_data = rdata;
        end
        m_busy = 0;
      end else if (m_busy && clr) begin
        m_keep = 0;
      end
      if (e_handle) begin
        li = line_of(addr);
        if (CACHE_ON && c_valid[li] && c_addr[li] == (addr & ~32'h3)) begin
          nxt_ready = 1; nxt_hit = 1; nxt_data = c_data[li];
        end else begin
          m_busy = 1; m_keep = 1; m_addr = addr & ~32'h3;
        end
      end
      m_ready = nxt_ready; m_hit = nxt_hit; m_data = nxt_data;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once
  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1; inst_req = 0; rob_clear = 0; rdy_in = 0; mem_done = 0;
    inst_addr = 32'h0; mem_rdata = 32'h0;
    #1;
    check_eq("rst_inst_ready", 32'(inst_ready), 32'd0);
    check_eq("rst_inst_data", inst_data, 32'h0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    reset_model();
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  // Complete any outstanding read and let the response retire
  task automatic drain();
    for (int i = 0; i < 20 && (m_busy || m_ready); i++)
      cycle(1'b0, 32'h0, 1'b0, 1'b1, m_busy, mem_word(m_addr));
    check_eq("drain_done", 32'(m_busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int mreq_cnt;
    reset_model();
    do_reset();

    // Cold fetch of 0x0: three mem_req cycles, response one cycle later
    cycle(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("cold_handle", 32'(s_handle), 32'd1);
    mreq_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, (i == 2), 32'h00000013);
      mreq_cnt += int'(s_mem_req);
    end
    check_eq("cold_mem_req_cycles", 32'(mreq_cnt), 32'd3);
    idle();
    check_eq("cold_ready", 32'(s_ready), 32'd1);
    check_eq("cold_data", s_data, 32'h00000013);
    idle();
    check_eq("cold_pulse_len", 32'(s_ready), 32'd0);

    // Refetch of 0x0: hit with one-cycle latency, no memory traffic
    cycle(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("refetch_handle", 32'(s_handle), 32'd1);
    idle();
    check_eq("refetch_ready", 32'(s_ready), 32'(CACHE_ON));
    check_eq("refetch_mem_req", 32'(s_mem_req), 32'(!CACHE_ON));
    drain();

    // Conflict on index 0: 0x40 evicts 0x0, which then misses again
    cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();
    check_eq("evict_miss_40", 32'(s_mem_req), 32'd1);
    drain();
    cycle(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();
    check_eq("evict_miss_0", 32'(s_mem_req), 32'd1);
    drain();

    // Flushed miss on 0x10: memory still completes and fills the line
    cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    idle();
    check_eq("drop_mem_req_held", 32'(s_mem_req), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000ABCD);
    idle();
    check_eq("drop_no_ready", 32'(s_ready), 32'd0);
    cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();
    check_eq("drop_refill_hit", 32'(s_ready), 32'(CACHE_ON));
    drain();

    // Flush in the response cycle of a hit; next request accepted after
    cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("flush_hit_ready", 32'(s_ready), 32'd0);
    cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("flush_next_handle", 32'(s_handle), 32'(CACHE_ON));
    drain();

    // rdy_in low for four cycles in MISS with mem_done held
    cycle(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000CAFE);
      check_eq("stall_mem_req", 32'(s_mem_req), 32'd1);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000CAFE);
    idle();
    check_eq("stall_ready", 32'(s_ready), 32'd1);
    check_eq("stall_data", s_data, 32'h0000CAFE);

    // Reset during a miss abandons it and invalidates all lines
    cycle(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();
    do_reset();
    cycle(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();
    check_eq("post_reset_miss", 32'(s_mem_req), 32'd1);
    drain();

    // Randomized traffic over a small address pool to mix hits and misses
    for (int n = 0; n < 3000; n++) begin
      logic        req, clr, rdy, done;
      logic [31:0] addr, rdata;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        req   = ($urandom_range(0, 3) != 0);
        addr  = 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
        clr   = ($urandom_range(0, 7) == 0);
        rdy   = ($urandom_range(0, 5) != 0);
        done  = m_busy && ($urandom_range(0, 2) == 0);
        rdata = ($urandom_range(0, 3) == 0) ? 32'($urandom) : mem_word(m_addr);
        cycle(req, addr, clr, rdy, done, rdata);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
